// File: rtl/mux_sel_ctrl.sv
// Select controller for a downstream 2:1 mux: a debounced pushbutton toggles sel,
// and an AUTO mode (from a synchronized switch) also toggles sel every AUTO_PERIOD cycles.
module mux_sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_PERIOD     = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key,
  input  logic auto_en,
  output logic sel,
  output logic sel_pulse,
  output logic mode
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int PW = $clog2(AUTO_PERIOD);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(AUTO_PERIOD - 1);

  localparam logic [0:0] ST_MANUAL = 1'b0;
  localparam logic [0:0] ST_AUTO   = 1'b1;

  // Synchronizers: key idles high (released), auto_en idles low (MANUAL).
  logic key_meta, ks;
  logic auto_meta, as_sync;

  logic          db;
  logic [DW-1:0] db_cnt;
  logic [PW-1:0] per_cnt;
  logic [0:0]    state;

  logic          db_next;
  logic [DW-1:0] db_cnt_next;
  logic [PW-1:0] per_cnt_next;
  logic [0:0]    state_next;
  logic          press;
  logic          expire;
  logic          toggle;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    db_next      = db;
    db_cnt_next  = '0;
    press        = 1'b0;
    expire       = 1'b0;
    per_cnt_next = '0;
    state_next   = as_sync ? ST_AUTO : ST_MANUAL;

    if (ks != db) begin
      if (db_cnt == DB_LAST) begin
        db_next = ks;
        press   = db;  // only the 1->0 (press) transition is an event
      end else begin
        db_cnt_next = db_cnt + 1'b1;
      end
    end

    // Period expiry only counts while AUTO persists across this edge.
    if (state == ST_AUTO && as_sync) begin
      expire = (per_cnt == PER_LAST);
      if (!expire && !press) begin
        per_cnt_next = per_cnt + 1'b1;
      end
    end

    // A coincident press and expiry must toggle once, hence OR rather than XOR.
    toggle = press | expire;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta  <= 1'b1;
      ks        <= 1'b1;
      auto_meta <= 1'b0;
      as_sync   <= 1'b0;
      db        <= 1'b1;
      db_cnt    <= '0;
      per_cnt   <= '0;
      state     <= ST_MANUAL;
      sel       <= 1'b0;
      sel_pulse <= 1'b0;
    end else begin
      key_meta  <= key;
      ks        <= key_meta;
      auto_meta <= auto_en;
      as_sync   <= auto_meta;
      db        <= db_next;
      db_cnt    <= db_cnt_next;
      per_cnt   <= per_cnt_next;
      state     <= state_next;
      sel       <= sel ^ toggle;
      sel_pulse <= toggle;
    end
  end

  assign mode = state[0];

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Self-checking bench for mux_sel_ctrl: per-edge vector tables applied through a
// scoreboard queue, plus hand-written reset-in-AUTO sequence.
module tb_mux_sel_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  logic key;
  logic auto_en;
  logic sel;
  logic sel_pulse;
  logic mode;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic key;
    logic auto_en;
    logic sel;
    logic pulse;
    logic mode;
  } vec_t;

  typedef struct packed {
    logic sel;
    logic pulse;
    logic mode;
  } exp_t;

  exp_t sb[$];

  vec_t va[1:22];
  vec_t vb[1:12];
  vec_t vc[1:66];

  mux_sel_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key       (key),
    .auto_en   (auto_en),
    .sel       (sel),
    .sel_pulse (sel_pulse),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: sel/pulse/mode got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one vector before the next rising edge; compare just after that edge.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    key     = v.key;
    auto_en = v.auto_en;
    sb.push_back('{sel: v.sel, pulse: v.pulse, mode: v.mode});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(name, {sel, sel_pulse, mode}, {e.sel, e.pulse, e.mode});
  endtask

  // Asserts reset between edges (outputs must clear with no clock), holds it
  // two edges, then releases so the next rising edge is functional edge 1.
  task automatic do_reset(input logic a, input string name);
    #2;
    reset_n = 1'b0;
    key     = 1'b1;
    auto_en = a;
    #1;
    check({name, "_async"}, {sel, sel_pulse, mode}, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_hold"}, {sel, sel_pulse, mode}, 3'b000);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic is_toggle_edge(input int e);
    int t[8] = '{11, 19, 27, 35, 43, 51, 57, 65};
    foreach (t[i]) if (t[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    reset_n = 1'b1;
    key     = 1'b1;
    auto_en = 1'b0;

    // Manual press at edge 1 -> db falls at edge 6; released from edge 9,
    // re-pressed from edge 15 -> db falls again at edge 20.
    for (int e = 1; e <= 22; e++) begin
      va[e].key     = (e <= 8 || e >= 15) ? 1'b0 : 1'b1;
      va[e].auto_en = 1'b0;
      va[e].sel     = (e >= 6 && e < 20);
      va[e].pulse   = (e == 6 || e == 20);
      va[e].mode    = 1'b0;
    end

    // Three-cycle glitch: never accepted.
    for (int e = 1; e <= 12; e++) begin
      vb[e] = '{key: (e <= 3) ? 1'b0 : 1'b1, auto_en: 1'b0, sel: 1'b0, pulse: 1'b0, mode: 1'b0};
    end

    // AUTO from reset: mode at edge 3, toggles every 8 edges from edge 11.
    // Press lands exactly on expiry at edge 35; second press at edge 57
    // mid-period restarts the count, so the next toggle is edge 65.
    begin
      logic s;
      s = 1'b0;
      for (int e = 1; e <= 66; e++) begin
        if (is_toggle_edge(e)) s = ~s;
        vc[e].key     = ((e >= 30 && e <= 44) || e >= 52) ? 1'b0 : 1'b1;
        vc[e].auto_en = 1'b1;
        vc[e].sel     = s;
        vc[e].pulse   = is_toggle_edge(e);
        vc[e].mode    = (e >= 3);
      end
    end

    do_reset(1'b0, "rst_a");
    for (int e = 1; e <= 22; e++) apply(va[e], $sformatf("manual_e%0d", e));

    do_reset(1'b0, "rst_b");
    for (int e = 1; e <= 12; e++) apply(vb[e], $sformatf("glitch_e%0d", e));

    do_reset(1'b1, "rst_c");
    for (int e = 1; e <= 66; e++) apply(vc[e], $sformatf("auto_e%0d", e));

    // Reset mid-AUTO with sel=1 and the period counter at 5 (after edge 16).
    do_reset(1'b1, "rst_d");
    for (int e = 1; e <= 16; e++) apply(vc[e], $sformatf("pre_rst_e%0d", e));
    do_reset(1'b1, "mid_auto_rst");
    for (int e = 1; e <= 12; e++) apply(vc[e], $sformatf("post_rst_e%0d", e));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_sel_ctrl.md
MUX_SEL_CTRL -- requirements
Module: mux_sel_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronized cycles needed to accept a key level change; legal range is >=1.
REQ-002 The block SHALL have parameter AUTO_PERIOD, default 8, meaning the cycles between automatic sel toggles; legal range is >=2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port key, input, 1 bit: raw, asynchronous pushbutton; 0 = pressed.
REQ-006 The block SHALL have port auto_en, input, 1 bit: raw, asynchronous switch; 1 requests AUTO mode.
REQ-007 The block SHALL have port sel, output, 1 bit: the registered select that drives the downstream 2:1 mux sel input.
REQ-008 The block SHALL have port sel_pulse, output, 1 bit: high for exactly one cycle after each edge at which sel changed.
REQ-009 The block SHALL have port mode, output, 1 bit: 0 = MANUAL, 1 = AUTO (registered FSM state).

Function
REQ-010 key and auto_en SHALL each pass through a 2-flop synchronizer (ks, as) before any other use.
REQ-011 Debounce: a debounced register db and a counter of width clog2(DEBOUNCE_CYCLES)+1 SHALL be used.
  - When ks==db, the counter clears.
  - When ks!=db and counter<DEBOUNCE_CYCLES-1, the counter increments.
  - When ks!=db and counter==DEBOUNCE_CYCLES-1, db takes ks and the counter clears.
REQ-012 A press event SHALL be the edge at which db changes from 1 to 0; a release (0->1) SHALL produce no event.
REQ-013 Latency: with key held low from before sampling edge 1, sel SHALL change at rising edge DEBOUNCE_CYCLES+2; this is edge 6 with the default parameter.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL cause no press event and no change to db.
REQ-015 The FSM SHALL have two states, MANUAL and AUTO.
  - MANUAL->AUTO occurs at the edge where as==1; AUTO->MANUAL occurs at the edge where as==0.
  - mode mirrors the state.
REQ-016 In MANUAL, each press event SHALL toggle sel at the same edge; the period counter is held at 0.
REQ-017 In AUTO, a period counter of width clog2(AUTO_PERIOD) SHALL count 0..AUTO_PERIOD-1.
  - At the edge where it equals AUTO_PERIOD-1, sel toggles and the counter wraps to 0.
  - sel therefore toggles every AUTO_PERIOD cycles.
REQ-018 On the MANUAL->AUTO transition edge, the period counter SHALL be 0 and sel SHALL be unchanged; the first auto toggle occurs AUTO_PERIOD edges later.
REQ-019 In AUTO, a press event SHALL toggle sel and clear the period counter to 0.
REQ-020 If a press event and period expiry coincide in AUTO, the block SHALL toggle sel exactly once and clear the counter to 0.
REQ-021 If a press event coincides with a mode-transition edge, the press SHALL toggle sel once, and the counter SHALL be 0 after that edge.
REQ-022 sel_pulse SHALL be registered and equal to (sel_next != sel) captured at the same edge; it is never high on two consecutive cycles in MANUAL mode.
REQ-023 Debouncing SHALL run continuously in both modes; a mode change SHALL NOT reset db or the debounce counter.

Reset
REQ-024 While reset_n==0, the block SHALL immediately and asynchronously force these values: sel=0, sel_pulse=0, mode=0 (MANUAL), synchronizer flops=1 for key and 0 for auto_en, db=1, and all counters=0.
REQ-025 An assertion of reset_n mid-debounce or mid-period SHALL discard all progress; after deassertion, behaviour SHALL be as from power-up.
REQ-026 Deassertion of reset_n SHALL be treated as asynchronous to clk by the block; the first functional edge is the first rising clk edge with reset_n==1.

Verification
REQ-027 Reset, then key=0 held from edge 1 -> sel 0->1 at edge 6, sel_pulse=1 for one cycle only; release and re-press -> sel returns to 0.
REQ-028 key=0 for 3 cycles then 1 (DEBOUNCE_CYCLES=4) -> sel stays 0, sel_pulse stays 0.
REQ-029 auto_en=1 from reset -> mode=1 after 2 edges plus the transition edge; sel toggles every 8 cycles (0,1,0,1...), with one sel_pulse per toggle.
REQ-030 In AUTO, time a press so that db falls on the edge where the period counter=7 -> exactly one toggle, counter=0, and the next toggle 8 edges later.
REQ-031 reset_n pulsed low mid-AUTO with sel=1 and counter=5 -> outputs go to 0 without a clock edge; after release, with auto_en=1, the first toggle occurs 8 edges after re-entering AUTO.
